// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default timing constants and width helper.
// Intended to be imported by both uart_tx and the future uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // 100 MHz / 115200 baud
    localparam int unsigned DefClksPerBit = 868;
    localparam int unsigned DefDataWidth  = 8;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1 while not cleared, wrapping at each bit boundary.
// bit_tick marks the last cycle of a bit; pre_tick marks the cycle before it.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntPre = CntW'(CLKS_PER_BIT - 2);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign bit_tick = (cnt_q == CntMax);
    assign pre_tick = (cnt_q == CntPre);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pulls one word per frame from an upstream FIFO and serialises it
// as start, DATA_WIDTH data bits (LSB first), optional parity and one stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int unsigned IdxW = idx_width(DATA_WIDTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  parity_q, parity_d;
    logic                  init_q;
    logic                  tx_q, tx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic start_ok;
    logic baud_clear;
    logic bit_tick;
    logic pre_tick;

    // Baud count only runs while a bit is actually on the line.
    assign baud_clear = (state_q == StIdle) || (state_q == StFetch) || (state_q == StLatch);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear),
        .bit_tick(bit_tick),
        .pre_tick(pre_tick)
    );

    // init_q holds off the first fetch for one edge after reset release.
    assign start_ok = init_q && tx_en && !fifo_empty;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                shift_d  = fifo_data;
                parity_d = (^fifo_data) ^ PARITY_ODD;
                idx_d    = '0;
                state_d  = StStart;
            end
            StStart: begin
                if (bit_tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_tick) begin
                    if (idx_q == IdxLast) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so the flops line up with the state.
        rd_en_d = (state_d == StFetch);
        // Stay busy across the idle gap when another frame is already queued.
        busy_d  = (state_d != StIdle) || start_ok;
        done_d  = (state_q == StStop) && pre_tick;

        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            init_q   <= 1'b0;
            tx_q     <= 1'b1;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            init_q   <= 1'b1;
            tx_q     <= tx_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: one DUT without parity, two with even/odd parity.
// Each DUT has a small FIFO model; tx is sampled on falling edges and compared bit by bit.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_en = 1'b0;

    always #5 clk = ~clk;

    // FIFO model and DUT without parity
    logic [7:0] mem_a [0:15];
    int         wr_a = 0;
    int         rd_a = 0;
    logic [7:0] data_a = 8'h00;
    logic       empty_a;
    logic       rd_en_a, tx_a, busy_a, done_a;
    assign empty_a = (wr_a == rd_a);

    always @(posedge clk) begin
        if (rd_en_a && (wr_a != rd_a)) begin
            data_a <= mem_a[rd_a[3:0]];
            rd_a   <= rd_a + 1;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(4),
        .DATA_WIDTH  (8),
        .PARITY_EN   (1'b0),
        .PARITY_ODD  (1'b0)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .fifo_empty(empty_a),
        .fifo_data (data_a),
        .fifo_rd_en(rd_en_a),
        .tx        (tx_a),
        .tx_busy   (busy_a),
        .tx_done   (done_a)
    );

    // Shared FIFO model for the two parity DUTs, which run in lockstep
    logic [7:0] mem_p [0:15];
    int         wr_p = 0;
    int         rd_p = 0;
    logic [7:0] data_p = 8'h00;
    logic       empty_p;
    logic       rd_en_pe, tx_pe, busy_pe, done_pe;
    logic       rd_en_po, tx_po, busy_po, done_po;
    assign empty_p = (wr_p == rd_p);

    always @(posedge clk) begin
        if (rd_en_pe && (wr_p != rd_p)) begin
            data_p <= mem_p[rd_p[3:0]];
            rd_p   <= rd_p + 1;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(4),
        .DATA_WIDTH  (8),
        .PARITY_EN   (1'b1),
        .PARITY_ODD  (1'b0)
    ) u_dut_pe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .fifo_empty(empty_p),
        .fifo_data (data_p),
        .fifo_rd_en(rd_en_pe),
        .tx        (tx_pe),
        .tx_busy   (busy_pe),
        .tx_done   (done_pe)
    );

    uart_tx #(
        .CLKS_PER_BIT(4),
        .DATA_WIDTH  (8),
        .PARITY_EN   (1'b1),
        .PARITY_ODD  (1'b1)
    ) u_dut_po (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .fifo_empty(empty_p),
        .fifo_data (data_p),
        .fifo_rd_en(rd_en_po),
        .tx        (tx_po),
        .tx_busy   (busy_po),
        .tx_done   (done_po)
    );

    // Event counters for the non-parity DUT
    int   rd_cnt_a = 0;
    int   done_cnt_a = 0;
    int   busy_fall_a = 0;
    int   tx_low_a = 0;
    logic busy_prev_a = 1'b0;

    always @(negedge clk) begin
        if (rd_en_a) rd_cnt_a <= rd_cnt_a + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (busy_prev_a && !busy_a) busy_fall_a <= busy_fall_a + 1;
        if (!tx_a) tx_low_a <= tx_low_a + 1;
        busy_prev_a <= busy_a;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        case (sel)
            0:       return tx_a;
            1:       return tx_pe;
            default: return tx_po;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_pe;
            default: return busy_po;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_pe;
            default: return done_po;
        endcase
    endfunction

    task automatic push_a(input logic [7:0] b);
        mem_a[wr_a[3:0]] = b;
        wr_a = wr_a + 1;
    endtask

    task automatic push_p(input logic [7:0] b);
        mem_p[wr_p[3:0]] = b;
        wr_p = wr_p + 1;
    endtask

    // Waits for the start bit (lat = falling edges waited), then checks every bit cell.
    task automatic rx_frame(input int sel, input logic [7:0] b, input int npar,
                            input logic pbit, input int drop_at, input string tag,
                            output int lat);
        int         nb;
        logic       exp_bit;
        logic [3:0] s4;
        int         busy_hi;
        int         done_hi;
        nb  = 10 + npar;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (tx_of(sel) !== 1'b0 && lat < 200);
        if (tx_of(sel) !== 1'b0) begin
            check_eq({tag, "_start_timeout"}, 32'd0, 32'd1);
            return;
        end
        busy_hi = 0;
        done_hi = 0;
        for (int k = 0; k < nb; k++) begin
            if (k == 0) exp_bit = 1'b0;
            else if (k <= 8) exp_bit = b[k-1];
            else if (npar != 0 && k == 9) exp_bit = pbit;
            else exp_bit = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                s4[c] = tx_of(sel);
                busy_hi += int'(busy_of(sel));
                done_hi += int'(done_of(sel));
                if (k * 4 + c == drop_at) tx_en = 1'b0;
            end
            check_eq($sformatf("%s_bit%0d", tag, k), {28'd0, s4}, {28'd0, {4{exp_bit}}});
        end
        check_eq({tag, "_busy_cycles"}, busy_hi, nb * 4);
        check_eq({tag, "_done_pulses"}, done_hi, 1);
        check_eq({tag, "_done_last"}, {31'd0, done_of(sel)}, 32'd1);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat2;
        int rd0, done0, fall0, low0;

        // Reset values
        wait_cycles(3);
        check_eq("rst_tx", {31'd0, tx_a}, 32'd1);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_rd_en", {31'd0, rd_en_a}, 32'd0);
        check_eq("rst_done", {31'd0, done_a}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(2);

        // Test 2: parity, even and odd in lockstep
        tx_en = 1'b1;
        push_p(8'h07);
        fork
            rx_frame(1, 8'h07, 1, 1'b1, -1, "t2_even", lat);
            rx_frame(2, 8'h07, 1, 1'b0, -1, "t2_odd", lat2);
        join
        wait_cycles(3);
        check_eq("t2_rd_consumed", rd_p, 1);

        // Test 1: single byte 0xA5
        rd0 = rd_cnt_a;
        done0 = done_cnt_a;
        push_a(8'hA5);
        rx_frame(0, 8'hA5, 0, 1'b0, -1, "t1", lat);
        wait_cycles(5);
        check_eq("t1_rd_pulses", rd_cnt_a - rd0, 1);
        check_eq("t1_done_pulses", done_cnt_a - done0, 1);
        check_eq("t1_busy_after", {31'd0, busy_a}, 32'd0);
        check_eq("t1_tx_idle", {31'd0, tx_a}, 32'd1);

        // Test 4: tx_en low holds off a non-empty FIFO
        tx_en = 1'b0;
        push_a(8'h3C);
        rd0 = rd_cnt_a;
        wait_cycles(2);
        low0 = tx_low_a;
        wait_cycles(10);
        check_eq("t4_no_rd", rd_cnt_a - rd0, 0);
        check_eq("t4_tx_high", tx_low_a - low0, 0);
        tx_en = 1'b1;
        rx_frame(0, 8'h3C, 0, 1'b0, -1, "t4", lat);
        check_eq("t4_latency", lat, 3);
        wait_cycles(5);

        // Test 3: three queued bytes back to back
        tx_en = 1'b0;
        push_a(8'h01);
        push_a(8'h02);
        push_a(8'h03);
        wait_cycles(2);
        rd0 = rd_cnt_a;
        fall0 = busy_fall_a;
        tx_en = 1'b1;
        rx_frame(0, 8'h01, 0, 1'b0, -1, "t3_f1", lat);
        check_eq("t3_f1_lat", lat, 3);
        rx_frame(0, 8'h02, 0, 1'b0, -1, "t3_f2", lat);
        check_eq("t3_gap12", lat, 4);
        rx_frame(0, 8'h03, 0, 1'b0, -1, "t3_f3", lat);
        check_eq("t3_gap23", lat, 4);
        wait_cycles(5);
        check_eq("t3_rd_pulses", rd_cnt_a - rd0, 3);
        check_eq("t3_busy_falls", busy_fall_a - fall0, 1);

        // Test 5: reset during data bit 3 of a 0x00 frame
        rd0 = rd_cnt_a;
        push_a(8'h00);
        push_a(8'h5A);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (tx_a !== 1'b0 && lat < 200);
        check_eq("t5_start_seen", {31'd0, tx_a}, 32'd0);
        wait_cycles(17);
        check_eq("t5_bit3_low", {31'd0, tx_a}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_tx", {31'd0, tx_a}, 32'd1);
        check_eq("t5_rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("t5_rst_rd_en", {31'd0, rd_en_a}, 32'd0);
        check_eq("t5_rst_done", {31'd0, done_a}, 32'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_no_early_rd", {31'd0, rd_en_a}, 32'd0);
        rx_frame(0, 8'h5A, 0, 1'b0, -1, "t5_next", lat);
        wait_cycles(5);
        check_eq("t5_rd_pulses", rd_cnt_a - rd0, 2);

        // Test 6: drop tx_en during data bit 2; frame completes, nothing new fetched
        rd0 = rd_cnt_a;
        push_a(8'h3C);
        push_a(8'hC3);
        rx_frame(0, 8'h3C, 0, 1'b0, 12, "t6", lat);
        low0 = tx_low_a;
        wait_cycles(20);
        check_eq("t6_rd_pulses", rd_cnt_a - rd0, 1);
        check_eq("t6_tx_high", tx_low_a - low0, 0);
        check_eq("t6_busy_after", {31'd0, busy_a}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
